// File: rtl/sik_encoder.sv
// SIK stack-ISA instruction encoder: turns symbolic instructions into 16-bit
// memory-image words, inserting a `pre` prefix for wide immediates and a final `sys`.
module sik_encoder #(
    parameter logic [15:0] BASE   = 16'h0000,
    parameter logic [15:0] STRIDE = 16'd1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic        in_ext,
    input  logic [3:0]  in_op,
    input  logic [15:0] in_immed,
    input  logic        seal,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] out_word,
    output logic [15:0] out_addr,
    output logic        err,
    output logic        done
);

    typedef enum logic [1:0] {
        IDLE,
        PRE,
        MAIN,
        SEALED
    } state_t;

    localparam logic [15:0] SYS_WORD = 16'h0009;

    state_t      state;
    logic [15:0] main_word;
    logic        terminal;

    logic        legal;
    logic        need_pre;
    logic [15:0] cand_main;
    logic [15:0] cand_pre;

    assign in_ready = (state == IDLE) && !done;

    // Classify the presented instruction; only used on the accept cycle.
    always_comb begin
        legal     = 1'b0;
        need_pre  = 1'b0;
        cand_main = {in_op, in_immed[11:0]};
        cand_pre  = {4'b1111, 8'h00, in_immed[15:12]};
        if (in_ext) begin
            cand_main = {12'h000, in_op};
            legal     = (in_op >= 4'd1) && (in_op <= 4'd12);
        end else begin
            case (in_op)
                4'h1, 4'h2, 4'h3: legal = (in_immed[15:12] == 4'h0);
                4'h4, 4'h5, 4'h6, 4'h7, 4'h8: begin
                    legal    = 1'b1;
                    need_pre = (in_immed[15:12] != 4'h0);
                end
                default: legal = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_word  <= 16'h0000;
            out_addr  <= BASE;
            err       <= 1'b0;
            done      <= 1'b0;
            main_word <= 16'h0000;
            terminal  <= 1'b0;
        end else begin
            err <= 1'b0;
            case (state)
                IDLE: begin
                    // seal wins over a simultaneous instruction, which is not taken.
                    if (seal) begin
                        main_word <= SYS_WORD;
                        terminal  <= 1'b1;
                        out_word  <= SYS_WORD;
                        out_valid <= 1'b1;
                        state     <= MAIN;
                    end else if (in_valid) begin
                        if (!legal) begin
                            err <= 1'b1;
                        end else begin
                            main_word <= cand_main;
                            terminal  <= 1'b0;
                            out_valid <= 1'b1;
                            if (need_pre) begin
                                out_word <= cand_pre;
                                state    <= PRE;
                            end else begin
                                out_word <= cand_main;
                                state    <= MAIN;
                            end
                        end
                    end
                end
                PRE: begin
                    if (out_ready) begin
                        out_addr <= out_addr + STRIDE;
                        out_word <= main_word;
                        state    <= MAIN;
                    end
                end
                MAIN: begin
                    if (out_ready) begin
                        out_addr  <= out_addr + STRIDE;
                        out_valid <= 1'b0;
                        if (terminal) begin
                            state <= SEALED;
                            done  <= 1'b1;
                        end else begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sik_encoder.sv
// Directed bench for sik_encoder: three instances share stimulus so one run
// covers the default layout, BASE=1/STRIDE=2, and an address wrap from FFFF.
module tb_sik_encoder;

    typedef struct {
        logic        ext;
        logic [3:0]  op;
        logic [15:0] immed;
        logic        exp_err;
        logic        exp_pre;
        logic [15:0] exp_prefix;
        logic [15:0] exp_main;
    } vec_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ext;
    logic [3:0]  in_op;
    logic [15:0] in_immed;
    logic        seal;
    logic        out_ready;

    logic        in_ready [3];
    logic        out_valid [3];
    logic [15:0] out_word [3];
    logic [15:0] out_addr [3];
    logic        err [3];
    logic        done [3];

    int n_vec;
    int n_fail;
    int word_idx;
    vec_t vecs [15];

    sik_encoder dut0 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[0]),
        .in_ext(in_ext), .in_op(in_op), .in_immed(in_immed), .seal(seal),
        .out_valid(out_valid[0]), .out_ready(out_ready), .out_word(out_word[0]),
        .out_addr(out_addr[0]), .err(err[0]), .done(done[0])
    );

    sik_encoder #(.BASE(16'h0001), .STRIDE(16'd2)) dut1 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[1]),
        .in_ext(in_ext), .in_op(in_op), .in_immed(in_immed), .seal(seal),
        .out_valid(out_valid[1]), .out_ready(out_ready), .out_word(out_word[1]),
        .out_addr(out_addr[1]), .err(err[1]), .done(done[1])
    );

    sik_encoder #(.BASE(16'hFFFF), .STRIDE(16'd2)) dut2 (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready[2]),
        .in_ext(in_ext), .in_op(in_op), .in_immed(in_immed), .seal(seal),
        .out_valid(out_valid[2]), .out_ready(out_ready), .out_word(out_word[2]),
        .out_addr(out_addr[2]), .err(err[2]), .done(done[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Expected address of word number word_idx since reset, per instance.
    task automatic check_word(input string name, input logic [15:0] exp);
        logic [15:0] k;
        k = word_idx[15:0];
        for (int d = 0; d < 3; d++) begin
            check_output({name, " valid"}, {15'd0, out_valid[d]}, 16'd1);
            check_output({name, " word"}, out_word[d], exp);
        end
        check_output({name, " addr0"}, out_addr[0], k);
        check_output({name, " addr1"}, out_addr[1], 16'h0001 + 16'd2 * k);
        check_output({name, " addr2"}, out_addr[2], 16'hFFFF + 16'd2 * k);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        word_idx = 0;
        for (int d = 0; d < 3; d++) begin
            check_output("rst valid", {15'd0, out_valid[d]}, 16'd0);
            check_output("rst word", out_word[d], 16'h0000);
            check_output("rst err", {15'd0, err[d]}, 16'd0);
            check_output("rst done", {15'd0, done[d]}, 16'd0);
            check_output("rst in_ready", {15'd0, in_ready[d]}, 16'd1);
        end
        check_output("rst addr0", out_addr[0], 16'h0000);
        check_output("rst addr1", out_addr[1], 16'h0001);
        check_output("rst addr2", out_addr[2], 16'hFFFF);
    endtask

    // Entered and left at a falling edge with out_ready high.
    task automatic apply_stimulus(input vec_t v);
        check_output("in_ready", {15'd0, in_ready[0]}, 16'd1);
        in_valid = 1'b1;
        in_ext   = v.ext;
        in_op    = v.op;
        in_immed = v.immed;
        @(negedge clk);
        in_valid = 1'b0;
        if (v.exp_err) begin
            check_output("err pulse", {15'd0, err[0]}, 16'd1);
            check_output("err no valid", {15'd0, out_valid[0]}, 16'd0);
            @(negedge clk);
            check_output("err clear", {15'd0, err[0]}, 16'd0);
            check_output("err still no valid", {15'd0, out_valid[0]}, 16'd0);
        end else begin
            check_output("no err", {15'd0, err[0]}, 16'd0);
            if (v.exp_pre) begin
                check_word("prefix", v.exp_prefix);
                @(negedge clk);
                word_idx++;
            end
            check_word("main", v.exp_main);
            @(negedge clk);
            word_idx++;
            check_output("idle valid", {15'd0, out_valid[0]}, 16'd0);
        end
    endtask

    initial begin
        n_vec = 0;
        n_fail = 0;
        word_idx = 0;
        reset = 1'b1;
        in_valid = 1'b0;
        in_ext = 1'b0;
        in_op = 4'h0;
        in_immed = 16'h0000;
        seal = 1'b0;
        out_ready = 1'b1;

        vecs[0]  = '{1'b0, 4'h8, 16'h0005, 1'b0, 1'b0, 16'h0000, 16'h8005};
        vecs[1]  = '{1'b0, 4'h6, 16'h3ABC, 1'b0, 1'b1, 16'hF003, 16'h6ABC};
        vecs[2]  = '{1'b1, 4'h1, 16'h1234, 1'b0, 1'b0, 16'h0000, 16'h0001};
        vecs[3]  = '{1'b1, 4'h7, 16'h0000, 1'b0, 1'b0, 16'h0000, 16'h0007};
        vecs[4]  = '{1'b0, 4'h1, 16'h1000, 1'b1, 1'b0, 16'h0000, 16'h0000};
        vecs[5]  = '{1'b0, 4'h8, 16'h0001, 1'b0, 1'b0, 16'h0000, 16'h8001};
        vecs[6]  = '{1'b0, 4'h4, 16'hFFFF, 1'b0, 1'b1, 16'hF00F, 16'h4FFF};
        vecs[7]  = '{1'b0, 4'h3, 16'h0ABC, 1'b0, 1'b0, 16'h0000, 16'h3ABC};
        vecs[8]  = '{1'b0, 4'h0, 16'h0001, 1'b1, 1'b0, 16'h0000, 16'h0000};
        vecs[9]  = '{1'b0, 4'hF, 16'h0002, 1'b1, 1'b0, 16'h0000, 16'h0000};
        vecs[10] = '{1'b1, 4'hD, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000};
        vecs[11] = '{1'b1, 4'h0, 16'h0000, 1'b1, 1'b0, 16'h0000, 16'h0000};
        vecs[12] = '{1'b0, 4'h9, 16'h0003, 1'b1, 1'b0, 16'h0000, 16'h0000};
        vecs[13] = '{1'b1, 4'hC, 16'hFFFF, 1'b0, 1'b0, 16'h0000, 16'h000C};
        vecs[14] = '{1'b0, 4'h2, 16'h0FFF, 1'b0, 1'b0, 16'h0000, 16'h2FFF};

        @(negedge clk);
        do_reset();
        for (int i = 0; i < 15; i++) begin
            apply_stimulus(vecs[i]);
        end

        // Prefix stalled for three cycles: word and address must not move.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_ext = 1'b0;
        in_op = 4'h7;
        in_immed = 16'h2123;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check_word("stall prefix", 16'hF002);
            if (i < 2) @(negedge clk);
        end
        out_ready = 1'b1;
        @(negedge clk);
        word_idx++;
        check_word("stall main", 16'h7123);
        @(negedge clk);
        word_idx++;
        check_output("stall idle", {15'd0, out_valid[0]}, 16'd0);

        // Reset while a prefix is pending drops it and restores BASE.
        out_ready = 1'b0;
        in_valid = 1'b1;
        in_op = 4'h6;
        in_immed = 16'h3ABC;
        @(negedge clk);
        in_valid = 1'b0;
        check_word("pending prefix", 16'hF003);
        do_reset();
        out_ready = 1'b1;
        @(negedge clk);
        check_output("post reset valid", {15'd0, out_valid[0]}, 16'd0);

        // seal together with an instruction: only sys is emitted, then sealed.
        apply_stimulus(vecs[0]);
        check_output("seal in_ready", {15'd0, in_ready[0]}, 16'd1);
        seal = 1'b1;
        in_valid = 1'b1;
        in_op = 4'h8;
        in_immed = 16'h0005;
        @(negedge clk);
        seal = 1'b0;
        check_output("seal ready drop", {15'd0, in_ready[0]}, 16'd0);
        check_output("seal not done", {15'd0, done[0]}, 16'd0);
        check_word("sys", 16'h0009);
        @(negedge clk);
        word_idx++;
        for (int i = 0; i < 3; i++) begin
            check_output("sealed done", {15'd0, done[0]}, 16'd1);
            check_output("sealed in_ready", {15'd0, in_ready[0]}, 16'd0);
            check_output("sealed valid", {15'd0, out_valid[0]}, 16'd0);
            check_output("sealed addr0", out_addr[0], word_idx[15:0]);
            @(negedge clk);
        end
        in_valid = 1'b0;
        do_reset();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
